// File: rtl/timer_ctrl.sv
// Front-panel control for the countdown timer: synchronises and debounces the
// start/pause and load buttons, runs the run-control FSM, and drives the
// datapath load strobe and count enable from the 1 Hz tick.
`timescale 1ns / 1ps

module timer_ctrl #(
    parameter int unsigned DEB_CYCLES = 1000000,
    parameter int unsigned DEB_W      = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_start,
    input  logic       btn_load,
    input  logic       tick_1hz,
    input  logic       done,
    input  logic       error,
    output logic       load,
    output logic       CE,
    output logic [2:0] mode,
    output logic       run_led
);

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StLoaded  = 3'd1,
        StRunning = 3'd2,
        StPaused  = 3'd3,
        StDone    = 3'd4,
        StError   = 3'd5
    } state_e;

    // Last counter value before the debounced level flips.
    localparam logic [DEB_W-1:0] DebLast = DEB_W'(DEB_CYCLES - 1);

    // Bit 0 is the start button, bit 1 the load button.
    logic [1:0]       sync1_q;
    logic [1:0]       sync2_q;
    logic [1:0]       deb_q;
    logic [1:0]       deb_prev_q;
    logic [DEB_W-1:0] cnt_q [2];

    logic   p_start;
    logic   p_load;
    state_e state_q;
    // High during the load-strobe cycle; the error check waits until it clears.
    logic   settle_q;

    // Two-flop synchronisers, mismatch-run debouncers and the edge-detect stage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            deb_q      <= '0;
            deb_prev_q <= '0;
            cnt_q[0]   <= '0;
            cnt_q[1]   <= '0;
        end else begin
            sync1_q    <= {btn_load, btn_start};
            sync2_q    <= sync1_q;
            deb_prev_q <= deb_q;
            for (int i = 0; i < 2; i++) begin
                if (sync2_q[i] != deb_q[i]) begin
                    if (cnt_q[i] == DebLast) begin
                        deb_q[i] <= sync2_q[i];
                        cnt_q[i] <= '0;
                    end else begin
                        cnt_q[i] <= cnt_q[i] + DEB_W'(1);
                    end
                end else begin
                    cnt_q[i] <= '0;
                end
            end
        end
    end

    // Press pulses fire on debounced rising edges only; releases are ignored.
    assign p_start = deb_q[0] & ~deb_prev_q[0];
    assign p_load  = deb_q[1] & ~deb_prev_q[1];

    // Run-control FSM with registered load/CE/run_led outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            settle_q <= 1'b0;
            load     <= 1'b0;
            CE       <= 1'b0;
            run_led  <= 1'b0;
        end else begin
            load <= 1'b0;
            // done beats a coincident tick, and a pause blocks the next tick.
            CE   <= tick_1hz && (state_q == StRunning) && !done;
            unique case (state_q)
                StIdle, StDone, StError: begin
                    if (p_load) begin
                        state_q  <= StLoaded;
                        settle_q <= 1'b1;
                        load     <= 1'b1;
                    end
                end
                StLoaded: begin
                    if (settle_q) begin
                        settle_q <= 1'b0;
                    end else if (error) begin
                        state_q <= StError;
                    end else if (p_load) begin
                        settle_q <= 1'b1;
                        load     <= 1'b1;
                    end else if (p_start) begin
                        state_q <= StRunning;
                        run_led <= 1'b1;
                    end
                end
                StRunning: begin
                    // Load presses are deliberately ignored while counting.
                    if (done) begin
                        state_q <= StDone;
                        run_led <= 1'b0;
                    end else if (p_start) begin
                        state_q <= StPaused;
                        run_led <= 1'b0;
                    end
                end
                StPaused: begin
                    if (p_load) begin
                        state_q  <= StLoaded;
                        settle_q <= 1'b1;
                        load     <= 1'b1;
                    end else if (p_start) begin
                        state_q <= StRunning;
                        run_led <= 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    run_led <= 1'b0;
                end
            endcase
        end
    end

    assign mode = state_q;

endmodule

// File: doc/timer_ctrl.md
# timer_ctrl

Front-panel control stage for the countdown timer. It debounces the start/pause and load push-buttons, runs the run-control state machine, and drives the timer datapath's `load` and `CE` inputs from the free-running 1 Hz tick. It also watches the datapath's `done` (LED) and `error` (ErrorLED) outputs, and publishes a mode code for the seven-segment display driver.

## Interface
- `DEB_CYCLES`, default 1000000: consecutive stable clocks needed to accept a button level (10 ms at 100 MHz). Benches use 4.
- `DEB_W`, default 20: debounce counter width. Must satisfy 2^DEB_W > DEB_CYCLES.
- `clk` in 1: system clock. All logic is on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `btn_start` in 1: raw start/pause button, asynchronous, active-high.
- `btn_load` in 1: raw load button, asynchronous, active-high.
- `tick_1hz` in 1: one-`clk`-wide pulse once per second, synchronous to `clk`.
- `done` in 1: timer reached 00:00 (datapath LED). Level.
- `error` in 1: loaded value invalid (datapath ErrorLED). Level.
- `load` out 1: one-cycle load strobe to the datapath.
- `CE` out 1: one-cycle count enable to the datapath.
- `mode` out 3: 0 IDLE, 1 LOADED, 2 RUNNING, 3 PAUSED, 4 DONE, 5 ERROR. Codes 6 and 7 are unused.
- `run_led` out 1: high while in RUNNING.

## Operation
- **Button path.** Each button passes through a 2-FF synchronizer and then a debouncer.
  - The debouncer keeps a counter while the synchronized level differs from the debounced level.
  - The counter clears whenever the two levels match.
  - When the counter reaches DEB_CYCLES consecutive mismatches, the debounced level flips.
  - A rising edge of the debounced level produces a one-cycle press pulse (`p_start` / `p_load`). Releases produce nothing.
- **FSM transitions.** All transitions are registered.
  - IDLE: `p_load` → LOADED (assert `load`). `p_start` is ignored.
  - LOADED: one cycle after entry, sample `error`. If high → ERROR. Otherwise `p_start` → RUNNING, and `p_load` → LOADED again (re-strobe `load`).
  - RUNNING: `done` high → DONE. Otherwise `p_start` → PAUSED. `p_load` is ignored.
  - PAUSED: `p_start` → RUNNING. `p_load` → LOADED (assert `load`).
  - DONE: `p_load` → LOADED (assert `load`). `p_start` is ignored.
  - ERROR: `p_load` → LOADED (assert `load`). `p_start` is ignored.
- **Simultaneous presses.** If `p_start` and `p_load` arrive in the same cycle, load wins in every state except RUNNING. In RUNNING, load is ignored and start is honoured.
- **Outputs.**
  - `CE` is registered: CE(n+1) = `tick_1hz`(n) AND state(n)==RUNNING AND NOT `done`(n).
  - If `done` and `tick_1hz` are high in the same cycle, `done` wins and no CE is issued.
  - `load` is registered and high for exactly one cycle, the cycle in which `mode` first shows LOADED.
  - `mode` and `run_led` are registered decodes of the state.
- **Reset.** Assertion of `reset` at any time, including mid-debounce or mid-RUNNING, forces the following immediately:
  - state IDLE, `mode`=0;
  - `load`=0, `CE`=0, `run_led`=0;
  - synchronizers, debounced levels and counters all 0.
- A button held through reset release produces a press only after a full debounce period.

## Timing
- Raw button edge to press pulse: 2 (sync) + DEB_CYCLES + 1 (edge detect) clocks.
- Press pulse to state/`mode`/`load` update: 1 clock.
- `tick_1hz` to `CE`: 1 clock. `CE` is never wider than one clock.
- The ERROR check samples `error` exactly one cycle after the `load` strobe, giving the datapath time to register the value.
- Pause takes effect at the same clock as the mode change. A tick arriving one cycle after the PAUSED transition yields no `CE`.
- Bounce shorter than DEB_CYCLES clocks produces no pulse. Holding a button produces exactly one pulse.

## Test plan
- **Reset values.** With DEB_CYCLES=4, assert `reset` mid-sequence → `mode`=0, `load`=0, `CE`=0, `run_led`=0 in the same cycle, with no clock edge required.
- **Bounce rejection.** Toggle `btn_load` high for 3 clocks, low for 1, then hold high → exactly one `load` pulse, arriving 7 clocks after the final rising edge. `mode` goes 0→1.
- **Load then run.** Load with `error`=0, then press start, then issue 5 `tick_1hz` pulses → 5 single-cycle `CE` pulses, each 1 clock after its tick. `mode`=2 and `run_led`=1.
- **Pause.** Press start during RUNNING → `mode`=3, and further ticks give `CE`=0. Press start again → `mode`=2 and `CE` resumes. Press load while RUNNING → no `load` pulse.
- **Done.** In RUNNING, raise `done` in the same cycle as a tick → no `CE`, `mode`=4. Press start → stays at 4. Press load → `load` pulse and `mode`=1.
- **Error recovery.** Load with `error` high one cycle after the strobe → `mode`=5. Press start → stays at 5. Press start and load in the same cycle → `load` pulse, `mode`=1, and with `error`=0 the state remains LOADED.
